control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - instruction fetch/decode sequencer driving a register-file DataPath
//
// Purpose: fetches 16-bit instructions over a req/ack instruction-memory port,
// decodes {opcode[15:12], operands[11:0]} and drives ALU/write controls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin execution at address 0 (honoured in IDLE/HALT only)
//   imem_req/imem_addr  fetch request and address (address is the PC)
//   imem_ack/imem_rdata fetch completion and instruction word
//   operands            IR[11:0] to DataPath
//   alu_cmd             ALU operation to DataPath
//   ctrl_sig            {reg_wr_en, dst_in_sel} to DataPath
//   busy/halted/illegal status: running, stopped, sticky illegal opcode

package alu;
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } AluCmd;
endpackage

package ctrl;
  typedef struct packed {
    logic reg_wr_en;
    logic dst_in_sel;
  } CtrlSig;
endpackage

module control_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [11:0]     operands,
  output alu::AluCmd      alu_cmd,
  output ctrl::CtrlSig    ctrl_sig,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [15:0]     r_ir;
  logic            r_illegal;
  logic            w_ir_load;
  logic            w_illegal_set;
  logic            w_illegal_clr;
  logic [3:0]      w_opcode;

  assign w_opcode  = r_ir[15:12];
  assign imem_addr = r_pc;
  assign operands  = r_ir[11:0];
  assign illegal   = r_illegal;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_ir_load     = 1'b0;
    w_illegal_set = 1'b0;
    w_illegal_clr = 1'b0;
    imem_req      = 1'b0;
    alu_cmd       = alu::ADD;
    ctrl_sig      = '0;
    busy          = 1'b0;
    halted        = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        halted = (r_state == S_HALT);
        if (start) begin
          w_pc_next     = '0;
          w_illegal_clr = 1'b1;
          w_state_next  = S_FETCH;
        end
      end

      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_load    = 1'b1;
          w_state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        busy = 1'b1;
        case (w_opcode)
          4'h0: begin
            w_pc_next    = r_pc + PC_W'(1);
            w_state_next = S_FETCH;
          end
          4'h1: begin
            ctrl_sig.reg_wr_en  = 1'b1;
            ctrl_sig.dst_in_sel = 1'b1;
            w_pc_next           = r_pc + PC_W'(1);
            w_state_next        = S_FETCH;
          end
          4'h2, 4'h3, 4'h4, 4'h5: begin
            ctrl_sig.reg_wr_en = 1'b1;
            case (w_opcode)
              4'h3:    alu_cmd = alu::SUB;
              4'h4:    alu_cmd = alu::AND;
              4'h5:    alu_cmd = alu::OR;
              default: alu_cmd = alu::ADD;
            endcase
            w_pc_next    = r_pc + PC_W'(1);
            w_state_next = S_FETCH;
          end
          4'hF: begin
            w_state_next = S_HALT;
          end
          default: begin
            // Unknown opcode: no write, PC frozen at the offending address.
            w_illegal_set = 1'b1;
            w_state_next  = S_HALT;
          end
        endcase
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
      if (w_illegal_set) begin
        r_illegal <= 1'b1;
      end else if (w_illegal_clr) begin
        r_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         imem_req;
  logic [7:0]   imem_addr;
  logic         imem_ack;
  logic [15:0]  imem_rdata;
  logic [11:0]  operands;
  alu::AluCmd   alu_cmd;
  ctrl::CtrlSig ctrl_sig;
  logic         busy;
  logic         halted;
  logic         illegal;

  logic         start2;
  logic         req2;
  logic [1:0]   addr2;
  logic         ack2;
  logic [15:0]  rdata2;
  logic [11:0]  operands2;
  alu::AluCmd   alu_cmd2;
  ctrl::CtrlSig ctrl2;
  logic         busy2;
  logic         halted2;
  logic         illegal2;

  control_unit #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .operands(operands), .alu_cmd(alu_cmd), .ctrl_sig(ctrl_sig),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  control_unit #(.PC_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .operands(operands2), .alu_cmd(alu_cmd2), .ctrl_sig(ctrl2),
    .busy(busy2), .halted(halted2), .illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [256];
  int          fixed_delay = 0;
  bit          rnd_delay = 0;
  bit          in_fetch = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  logic [7:0]  fetch_addr = 8'd0;
  int          addr_viol = 0;
  int          proto_viol = 0;

  int          fetch_log[$];
  int          delay_log[$];
  logic [14:0] wr_log[$];
  int          exp_addr[$];
  logic [14:0] exp_wr[$];
  int          fetch2_log[$];

  // Instruction memory: acks after a chosen number of wait cycles; in random
  // mode it also throws spurious acks with junk data outside fetches.
  always @(negedge clk) begin
    if (imem_req) begin
      if (!in_fetch) begin
        in_fetch   = 1'b1;
        wait_cnt   = 0;
        cur_delay  = rnd_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        fetch_addr = imem_addr;
        delay_log.push_back(cur_delay);
      end else if (imem_addr !== fetch_addr) begin
        addr_viol++;
      end
      if (wait_cnt == cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        fetch_log.push_back(int'(imem_addr));
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
      end
      wait_cnt++;
    end else begin
      in_fetch   = 1'b0;
      imem_ack   = rnd_delay ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    ack2 = req2;
    if (req2) fetch2_log.push_back(int'(addr2));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ctrl_sig.reg_wr_en) wr_log.push_back({alu_cmd, ctrl_sig.dst_in_sel, operands});
      if (ctrl_sig.reg_wr_en && !(busy && !imem_req)) proto_viol++;
      if (!ctrl_sig.reg_wr_en && alu_cmd != alu::ADD) proto_viol++;
      if (ctrl_sig.dst_in_sel && !ctrl_sig.reg_wr_en) proto_viol++;
    end
  end

  function automatic bit addrs_match();
    if (fetch_log.size() != exp_addr.size()) return 1'b0;
    foreach (exp_addr[i]) if (fetch_log[i] != exp_addr[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit writes_match();
    if (wr_log.size() != exp_wr.size()) return 1'b0;
    foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic alu::AluCmd cmd_of(input logic [3:0] op);
    case (op)
      4'h3:    return alu::SUB;
      4'h4:    return alu::AND;
      4'h5:    return alu::OR;
      default: return alu::ADD;
    endcase
  endfunction

  // ISA-level interpreter over mem[]: expected fetch order, writes, illegal flag.
  task automatic model_run(output bit ill);
    int pc;
    logic [15:0] w;
    logic [3:0] op;
    pc = 0;
    ill = 1'b0;
    exp_addr.delete();
    exp_wr.delete();
    for (int s = 0; s < 300; s++) begin
      w = mem[pc];
      op = w[15:12];
      exp_addr.push_back(pc);
      if (op == 4'h1) exp_wr.push_back({alu::ADD, 1'b1, w[11:0]});
      else if (op >= 4'h2 && op <= 4'h5) exp_wr.push_back({cmd_of(op), 1'b0, w[11:0]});
      if (op == 4'hF) break;
      if (op >= 4'h6 && op <= 4'hE) begin
        ill = 1'b1;
        break;
      end
      pc = (pc + 1) % 256;
    end
  endtask

  task automatic clear_logs();
    fetch_log.delete();
    delay_log.delete();
    wr_log.delete();
    addr_viol = 0;
    proto_viol = 0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cycles = rising edges from the start-sampling edge until halted is seen.
  task automatic wait_halt(output int cycles);
    cycles = 1;
    while (!halted && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run(input int delay, input bit rnd, output int cycles);
    clear_logs();
    fixed_delay = delay;
    rnd_delay = rnd;
    launch();
    wait_halt(cycles);
  endtask

  task automatic load_demo();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[0] = 16'h1114;
    mem[1] = 16'h130A;
    mem[2] = 16'h2513;
    mem[3] = 16'hF000;
  endtask

  task automatic demo_expect();
    exp_addr = '{0, 1, 2, 3};
    exp_wr.delete();
    exp_wr.push_back({alu::ADD, 1'b1, 12'h114});
    exp_wr.push_back({alu::ADD, 1'b1, 12'h30A});
    exp_wr.push_back({alu::ADD, 1'b0, 12'h513});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    rdata2 = 16'h0000;
    #12;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_status: got busy=%0b halted=%0b illegal=%0b want 000", busy, halted, illegal); end
    checks++; if (ctrl_sig !== 2'b00 || alu_cmd !== alu::ADD) begin failures++; $display("FAIL reset_ctrl: got ctrl=%b alu=%0d want 00/ADD", ctrl_sig, alu_cmd); end
    checks++; if (imem_addr !== 8'd0 || operands !== 12'd0) begin failures++; $display("FAIL reset_pc_ir: got addr=%0d ops=%h want 0/0", imem_addr, operands); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_stay_idle: got busy=%0b req=%0b halted=%0b want 000", busy, imem_req, halted); end
  endtask

  task automatic test_demo_zero_wait();
    int cyc;
    load_demo();
    demo_expect();
    run(0, 1'b0, cyc);
    // start edge plus 4 instructions x (FETCH, EXEC)
    checks++; if (cyc != 9) begin failures++; $display("FAIL demo_cycles: got %0d want 9", cyc); end
    checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL demo_status: got halted=%0b illegal=%0b want 1/0", halted, illegal); end
    checks++; if (imem_addr !== 8'd3) begin failures++; $display("FAIL demo_pc: got %0d want 3", imem_addr); end
    checks++; if (!writes_match()) begin failures++; $display("FAIL demo_writes: got %0d writes want 3 matching", wr_log.size()); end
    checks++; if (!addrs_match()) begin failures++; $display("FAIL demo_fetch_order: got %0d fetches want 0,1,2,3", fetch_log.size()); end
    checks++; if (proto_viol != 0) begin failures++; $display("FAIL demo_ctrl_rules: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_demo_wait();
    int cyc;
    load_demo();
    demo_expect();
    run(3, 1'b0, cyc);
    checks++; if (cyc != 21) begin failures++; $display("FAIL wait_cycles: got %0d want 21", cyc); end
    checks++; if (addr_viol != 0) begin failures++; $display("FAIL wait_addr_stable: got %0d changes want 0", addr_viol); end
    checks++; if (!writes_match()) begin failures++; $display("FAIL wait_writes: got %0d writes want 3 matching", wr_log.size()); end
    checks++; if (imem_addr !== 8'd3 || halted !== 1'b1) begin failures++; $display("FAIL wait_end: got addr=%0d halted=%0b want 3/1", imem_addr, halted); end
  endtask

  task automatic test_illegal();
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[0] = 16'h7000;
    run(0, 1'b0, cyc);
    checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL illegal_flag: got illegal=%0b halted=%0b want 1/1", illegal, halted); end
    checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL illegal_no_write: got %0d writes want 0", wr_log.size()); end
    checks++; if (imem_addr !== 8'd0) begin failures++; $display("FAIL illegal_pc: got %0d want 0", imem_addr); end
    mem[0] = 16'hF000;
    clear_logs();
    launch();
    checks++; if (illegal !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'd0) begin failures++; $display("FAIL illegal_restart: got illegal=%0b req=%0b addr=%0d want 0/1/0", illegal, imem_req, imem_addr); end
    wait_halt(cyc);
    exp_addr = '{0};
    checks++; if (!addrs_match() || halted !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL illegal_refetch: got %0d fetches halted=%0b illegal=%0b want 1/1/0", fetch_log.size(), halted, illegal); end
  endtask

  task automatic test_start_in_exec();
    int cyc;
    int n_exec;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[0] = 16'h0000;
    mem[1] = 16'h1234;
    mem[2] = 16'h0000;
    clear_logs();
    fixed_delay = 1;
    rnd_delay = 1'b0;
    launch();
    n_exec = 0;
    guard = 0;
    while (n_exec < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (busy && !imem_req) n_exec++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt(cyc);
    exp_addr = '{0, 1, 2, 3};
    exp_wr.delete();
    exp_wr.push_back({alu::ADD, 1'b1, 12'h234});
    checks++; if (!addrs_match()) begin failures++; $display("FAIL exec_start_order: got %0d fetches want 0,1,2,3", fetch_log.size()); end
    checks++; if (!writes_match()) begin failures++; $display("FAIL exec_start_writes: got %0d writes want 1", wr_log.size()); end
    checks++; if (imem_addr !== 8'd3 || halted !== 1'b1) begin failures++; $display("FAIL exec_start_end: got addr=%0d halted=%0b want 3/1", imem_addr, halted); end
  endtask

  task automatic test_random();
    int cyc;
    int exp_cyc;
    int r;
    bit exp_ill;
    logic [3:0] op;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 19));
        if (r < 12) op = 4'($urandom_range(1, 5));
        else if (r < 15) op = 4'h0;
        else if (r < 17) op = 4'($urandom_range(6, 14));
        else op = 4'hF;
        mem[i] = {op, 12'($urandom)};
      end
      model_run(exp_ill);
      run(0, 1'b1, cyc);
      exp_cyc = 1;
      foreach (delay_log[i]) exp_cyc += 2 + delay_log[i];
      checks++; if (!addrs_match()) begin failures++; $display("FAIL rnd%0d_fetch: got %0d fetches want %0d", it, fetch_log.size(), exp_addr.size()); end
      checks++; if (!writes_match()) begin failures++; $display("FAIL rnd%0d_writes: got %0d writes want %0d", it, wr_log.size(), exp_wr.size()); end
      checks++; if (illegal !== exp_ill || halted !== 1'b1) begin failures++; $display("FAIL rnd%0d_status: got illegal=%0b halted=%0b want %0b/1", it, illegal, halted, exp_ill); end
      checks++; if (int'(imem_addr) != exp_addr[exp_addr.size()-1]) begin failures++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, imem_addr, exp_addr[exp_addr.size()-1]); end
      checks++; if (cyc != exp_cyc) begin failures++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cyc, exp_cyc); end
      checks++; if (addr_viol != 0 || proto_viol != 0) begin failures++; $display("FAIL rnd%0d_rules: got addr=%0d ctrl=%0d violations want 0/0", it, addr_viol, proto_viol); end
    end
    rnd_delay = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    fetch2_log.delete();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    ok = (fetch2_log.size() >= 5);
    if (ok) for (int i = 0; i < 5; i++) if (fetch2_log[i] != i % 4) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL wrap_order: got %0d fetches first=%0d want 0,1,2,3,0", fetch2_log.size(), (fetch2_log.size() > 0) ? fetch2_log[0] : -1); end
  endtask

  task automatic test_reset_mid_fetch();
    load_demo();
    clear_logs();
    fixed_delay = 0;
    rnd_delay = 1'b0;
    launch();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_drop: got req=%0b busy=%0b want 0/0", imem_req, busy); end
    checks++; if (ctrl_sig !== 2'b00 || halted !== 1'b0 || imem_addr !== 8'd0) begin failures++; $display("FAIL midrst_outputs: got ctrl=%b halted=%0b addr=%0d want 00/0/0", ctrl_sig, halted, imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (operands !== 12'd0) begin failures++; $display("FAIL midrst_ack_discard: got ops=%h want 000", operands); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL midrst_idle: got busy=%0b req=%0b halted=%0b want 000", busy, imem_req, halted); end
    checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL midrst_no_write: got %0d writes want 0", wr_log.size()); end
  endtask

  initial begin
    test_reset();
    test_demo_zero_wait();
    test_demo_wait();
    test_illegal();
    test_start_in_exec();
    test_random();
    test_wrap();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
